inst_fetch_responder: RTL

//  Memory-side responder for instruction fetch: serves the core's fetch requests. It

---
 rtl/inst_fetch_responder_pkg.sv | 31 +++
 rtl/inst_fetch_responder_if.sv | 47 ++++
 rtl/fetch_req_fifo.sv | 60 ++++++
 rtl/inst_fetch_responder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/inst_fetch_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder: FSM encodings,
// the buffered request record, the debug view and the address legality check.
package inst_fetch_responder_pkg;

  localparam logic [63:0] PC_START_DEFAULT = 64'h8000_0000;

  localparam logic [1:0] IFR_IDLE = 2'd0;
  localparam logic [1:0] IFR_WAIT = 2'd1;
  localparam logic [1:0] IFR_READ = 2'd2;
  localparam logic [1:0] IFR_RESP = 2'd3;

  // One buffered fetch: the error verdict is taken at push time and travels with the PC.
  typedef struct packed {
    logic        err;
    logic [63:0] addr;
  } fetch_entry_t;

  typedef struct packed {
    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic [7:0] fifo_level;
  } ifr_dbg_t;

  // limit is the first byte address past the RAM (unsigned 64-bit compare).
  function automatic logic fetch_addr_err(input logic [63:0] addr,
                                          input logic [63:0] base,
                                          input logic [63:0] limit);
    return (addr[1:0] != 2'b00) || (addr < base) || (addr >= limit);
  endfunction

endpackage

// File: rtl/inst_fetch_responder_if.sv
// Fetch request/response channels plus the simulation-RAM read port.
// Valid/ready: a transfer happens on a rising clk edge where valid & ready are both 1;
// once raised, valid and its payload stay unchanged until that edge.
interface inst_fetch_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic        resp_err;

  logic        ram_en;
  logic [63:0] ram_ridx;
  logic [63:0] ram_rdata;

  // Environment side: the IF stage and the RAM model.
  modport master (
    output req_valid,
    output req_addr,
    output resp_ready,
    output ram_rdata,
    input  req_ready,
    input  resp_valid,
    input  resp_inst,
    input  resp_err,
    input  ram_en,
    input  ram_ridx
  );

  // Responder side.
  modport slave (
    input  req_valid,
    input  req_addr,
    input  resp_ready,
    input  ram_rdata,
    output req_ready,
    output resp_valid,
    output resp_inst,
    output resp_err,
    output ram_en,
    output ram_ridx
  );

endinterface

// File: rtl/fetch_req_fifo.sv
// In-order request buffer of {err, addr}; pointers carry one extra wrap bit so that
// full and empty are distinguishable when the index bits match.
module fetch_req_fifo
  import inst_fetch_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               wr_entry,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_entry;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/inst_fetch_responder.sv
// Memory-side responder for instruction fetch: buffers PCs, waits RESP_LATENCY cycles,
// reads one 64-bit RAM word and returns the addressed 32-bit lane with an error flag.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter logic [63:0] PC_START     = PC_START_DEFAULT,
  parameter int unsigned MEM_WORDS    = 65536,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned RESP_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  inst_fetch_responder_if.slave   bus,
  output ifr_dbg_t                dbg
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [63:0] MEM_LIMIT = PC_START + (64'(MEM_WORDS) << 3);
  localparam logic [7:0]  LAT       = 8'(RESP_LATENCY);

  logic         fifo_full;
  logic         fifo_empty;
  logic [AW:0]  fifo_level;
  logic         push;
  logic         pop;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  logic         ready_en_q, ready_en_d;
  logic [1:0]   state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [31:0]  inst_q, inst_d;
  logic         err_q, err_d;
  logic [31:0]  rdata_lane;

  // Held low through reset and for the first edge after release.
  assign ready_en_d    = 1'b1;
  assign bus.req_ready = ready_en_q && !fifo_full;
  assign push          = bus.req_valid && bus.req_ready;

  assign wr_entry.err  = fetch_addr_err(bus.req_addr, PC_START, MEM_LIMIT);
  assign wr_entry.addr = bus.req_addr;

  fetch_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .wr_entry (wr_entry),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign rdata_lane = head.addr[2] ? bus.ram_rdata[63:32] : bus.ram_rdata[31:0];

  // The RAM read is issued on the last WAIT cycle; the word arrives during READ.
  assign bus.ram_en   = (state_q == IFR_WAIT) && (cnt_q == 8'd0);
  assign bus.ram_ridx = bus.ram_en ? ((head.addr - PC_START) >> 3) : 64'd0;

  assign bus.resp_valid = (state_q == IFR_RESP);
  assign bus.resp_inst  = inst_q;
  assign bus.resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inst_d  = inst_q;
    err_d   = err_q;
    pop     = 1'b0;
    case (state_q)
      IFR_IDLE: begin
        if (!fifo_empty) begin
          if (head.err) begin
            pop     = 1'b1;
            err_d   = 1'b1;
            inst_d  = 32'h0;
            state_d = IFR_RESP;
          end else begin
            cnt_d   = LAT;
            state_d = IFR_WAIT;
          end
        end
      end
      IFR_WAIT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = IFR_READ;
        end
      end
      IFR_READ: begin
        inst_d  = rdata_lane;
        err_d   = 1'b0;
        pop     = 1'b1;
        state_d = IFR_RESP;
      end
      IFR_RESP: begin
        if (bus.resp_ready) begin
          state_d = IFR_IDLE;
        end
      end
      default: begin
        state_d = IFR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q <= 1'b0;
      state_q    <= IFR_IDLE;
      cnt_q      <= 8'd0;
      inst_q     <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      ready_en_q <= ready_en_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inst_q     <= inst_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    dbg            = '0;
    dbg.state      = state_q;
    dbg.wait_cnt   = cnt_q;
    dbg.fifo_level = 8'(fifo_level);
  end

endmodule
